// File: rtl/edge_burst_monitor_if.sv
// Bus bundle for edge_burst_monitor: control/sample inputs and per-channel status outputs.
// The master side drives clear/signal/edge_sel; the slave side (the monitor) drives the status.
interface edge_burst_monitor_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 4
);
    logic                      clear;
    logic [CHANNELS-1:0]       signal;
    logic [1:0]                edge_sel;
    logic [CHANNELS-1:0]       active;
    logic [CHANNELS-1:0]       hit;
    logic [CHANNELS-1:0]       done;
    logic [CHANNELS*CNT_W-1:0] count;

    modport master (
        output clear, signal, edge_sel,
        input  active, hit, done, count
    );

    modport slave (
        input  clear, signal, edge_sel,
        output active, hit, done, count
    );
endinterface

// File: rtl/edge_burst_monitor.sv
// Multi-channel edge-burst detector: an edge opens a WINDOW-sample window, hit flags THRESH edges.
// Optional macro RETRIGGER_EN lets an edge on the closing sample open the next window at once.
module edge_burst_monitor #(
    parameter int CHANNELS = 4,
    parameter int WINDOW   = 8,
    parameter int THRESH   = 3,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    edge_burst_monitor_if.slave bus
);
    localparam int              WC_W     = $clog2(WINDOW + 1);
    localparam logic [WC_W-1:0] WC_ONE   = WC_W'(1);
    localparam logic [WC_W-1:0] WC_LAST  = WC_W'(WINDOW);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THR_V   = CNT_W'(THRESH);
    localparam logic            OPEN_HIT = 1'(THRESH == 1);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

    state_e              state_r    [CHANNELS];
    state_e              state_nx_s [CHANNELS];
    logic [WC_W-1:0]     wcnt_r     [CHANNELS];
    logic [WC_W-1:0]     wcnt_nx_s  [CHANNELS];
    logic [CNT_W-1:0]    count_r    [CHANNELS];
    logic [CNT_W-1:0]    count_nx_s [CHANNELS];
    logic [CHANNELS-1:0] prev_r;
    logic [CHANNELS-1:0] hit_r;
    logic [CHANNELS-1:0] done_r;
    logic [CHANNELS-1:0] hit_nx_s;
    logic [CHANNELS-1:0] done_nx_s;
    logic [CHANNELS-1:0] edge_s;

    // 11 is treated as rising so every encoding has a defined meaning
    function automatic logic edge_qual(input logic p, input logic s, input logic [1:0] sel);
        case (sel)
            2'b00:   edge_qual = ~p & s;
            2'b01:   edge_qual = p & ~s;
            2'b10:   edge_qual = p ^ s;
            default: edge_qual = ~p & s;
        endcase
    endfunction

    // Qualified edge per channel from the previous and current sample
    always_comb begin
        edge_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            edge_s[i] = edge_qual(prev_r[i], bus.signal[i], bus.edge_sel);
        end
    end

    // State register: async reset; prev tracks the input even while clear is asserted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_r <= {CHANNELS{1'b0}};
            hit_r  <= {CHANNELS{1'b0}};
            done_r <= {CHANNELS{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                state_r[i] <= IDLE;
                wcnt_r[i]  <= {WC_W{1'b0}};
                count_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            prev_r  <= bus.signal;
            hit_r   <= hit_nx_s;
            done_r  <= done_nx_s;
            state_r <= state_nx_s;
            wcnt_r  <= wcnt_nx_s;
            count_r <= count_nx_s;
        end
    end

    // Next-state logic: open on edge, count inside the window, close on sample WINDOW+1
    always_comb begin
        logic [CNT_W-1:0] inc_s;
        state_nx_s = state_r;
        wcnt_nx_s  = wcnt_r;
        count_nx_s = count_r;
        hit_nx_s   = hit_r;
        done_nx_s  = {CHANNELS{1'b0}};
        inc_s      = {CNT_W{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            inc_s = (count_r[i] == CNT_MAX) ? CNT_MAX : count_r[i] + CNT_ONE;
            if (bus.clear) begin
                state_nx_s[i] = IDLE;
                wcnt_nx_s[i]  = {WC_W{1'b0}};
                count_nx_s[i] = {CNT_W{1'b0}};
                hit_nx_s[i]   = 1'b0;
            end else begin
                case (state_r[i])
                    IDLE: begin
                        if (edge_s[i]) begin
                            state_nx_s[i] = ACTIVE;
                            wcnt_nx_s[i]  = WC_ONE;
                            count_nx_s[i] = CNT_ONE;
                            hit_nx_s[i]   = OPEN_HIT;
                        end else begin
                            state_nx_s[i] = IDLE;
                        end
                    end
                    ACTIVE: begin
                        if (wcnt_r[i] < WC_LAST) begin
                            wcnt_nx_s[i] = wcnt_r[i] + WC_ONE;
                            if (edge_s[i]) begin
                                count_nx_s[i] = inc_s;
                                hit_nx_s[i]   = hit_r[i] | (inc_s >= THR_V);
                            end else begin
                                count_nx_s[i] = count_r[i];
                            end
                        end else begin
                            done_nx_s[i]  = 1'b1;
                            state_nx_s[i] = IDLE;
                            wcnt_nx_s[i]  = {WC_W{1'b0}};
`ifdef RETRIGGER_EN
                            if (edge_s[i]) begin
                                state_nx_s[i] = ACTIVE;
                                wcnt_nx_s[i]  = WC_ONE;
                                count_nx_s[i] = CNT_ONE;
                                hit_nx_s[i]   = OPEN_HIT;
                            end else begin
                                count_nx_s[i] = count_r[i];
                            end
`else
                            count_nx_s[i] = count_r[i];
`endif
                        end
                    end
                    default: begin
                        state_nx_s[i] = IDLE;
                        wcnt_nx_s[i]  = {WC_W{1'b0}};
                    end
                endcase
            end
        end
    end

    // Outputs come straight from registers: no combinational input-to-output path
    always_comb begin
        bus.active = {CHANNELS{1'b0}};
        bus.count  = {(CHANNELS*CNT_W){1'b0}};
        bus.hit    = hit_r;
        bus.done   = done_r;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.active[i]                = (state_r[i] == ACTIVE);
            bus.count[i*CNT_W +: CNT_W]  = count_r[i];
        end
    end
endmodule

// File: tb/tb_edge_burst_monitor.sv
// Table-driven bench for edge_burst_monitor: a THRESH=3 and a THRESH=1 instance share stimulus.
module tb_edge_burst_monitor;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   n_cmp = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    edge_burst_monitor_if #(.CHANNELS(4), .CNT_W(4)) bus ();
    edge_burst_monitor_if #(.CHANNELS(4), .CNT_W(4)) bus1 ();

    assign bus1.clear    = bus.clear;
    assign bus1.signal   = bus.signal;
    assign bus1.edge_sel = bus.edge_sel;

    edge_burst_monitor #(.CHANNELS(4), .WINDOW(8), .THRESH(3), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    edge_burst_monitor #(.CHANNELS(4), .WINDOW(8), .THRESH(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    typedef struct {
        logic        clr;
        logic [3:0]  sig;
        logic [1:0]  esel;
        int          reps;
        logic [3:0]  act;
        logic [3:0]  hit;
        logic [3:0]  hit1;
        logic [3:0]  done;
        logic [15:0] cnt;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];

    function automatic vec_t mk(input logic c, input logic [3:0] s, input logic [1:0] e, input int r,
                                input logic [3:0] a, input logic [3:0] h, input logic [3:0] h1,
                                input logic [3:0] d, input logic [15:0] n);
        vec_t v;
        v.clr = c; v.sig = s; v.esel = e; v.reps = r;
        v.act = a; v.hit = h; v.hit1 = h1; v.done = d; v.cnt = n;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s vector %0d: got %0h expected %0h", name, vectors, got, want);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        for (int r = 0; r < v.reps; r++) begin
            @(negedge clk);
            bus.clear    = v.clr;
            bus.signal   = v.sig;
            bus.edge_sel = v.esel;
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            vectors++;
            chk("active", 32'(bus.active), 32'(e.act));
            chk("hit",    32'(bus.hit),    32'(e.hit));
            chk("done",   32'(bus.done),   32'(e.done));
            chk("count",  32'(bus.count),  32'(e.cnt));
            chk("active_t1", 32'(bus1.active), 32'(e.act));
            chk("hit_t1",    32'(bus1.hit),    32'(e.hit1));
            chk("done_t1",   32'(bus1.done),   32'(e.done));
            chk("count_t1",  32'(bus1.count),  32'(e.cnt));
        end
    endtask

    task automatic chk_zero(input string tag);
        vectors++;
        chk({tag, "_active"}, 32'({bus.active, bus1.active}), 32'h0000_0000);
        chk({tag, "_hit"},    32'({bus.hit, bus1.hit}),       32'h0000_0000);
        chk({tag, "_done"},   32'({bus.done, bus1.done}),     32'h0000_0000);
        chk({tag, "_count"},  {bus.count, bus1.count},        32'h0000_0000);
    endtask

    initial begin
        reset        = 1'b1;
        bus.clear    = 1'b0;
        bus.signal   = 4'b0001;
        bus.edge_sel = 2'b00;
        @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;

        // clr, sig, esel, reps, active, hit, hit(THRESH=1), done, count{c3,c2,c1,c0}
        tbl.push_back(mk(1'b0, 4'b0001, 2'b00, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 16'h0001));
        tbl.push_back(mk(1'b0, 4'b0110, 2'b00, 1, 4'b0111, 4'b0000, 4'b0111, 4'b0000, 16'h0111));
        tbl.push_back(mk(1'b0, 4'b0001, 2'b00, 1, 4'b0111, 4'b0000, 4'b0111, 4'b0000, 16'h0112));
        tbl.push_back(mk(1'b0, 4'b0110, 2'b00, 1, 4'b0111, 4'b0000, 4'b0111, 4'b0000, 16'h0222));
        tbl.push_back(mk(1'b0, 4'b0111, 2'b00, 1, 4'b0111, 4'b0001, 4'b0111, 4'b0000, 16'h0223));
        tbl.push_back(mk(1'b0, 4'b0111, 2'b00, 3, 4'b0111, 4'b0001, 4'b0111, 4'b0000, 16'h0223));
        tbl.push_back(mk(1'b0, 4'b0111, 2'b00, 1, 4'b0110, 4'b0001, 4'b0111, 4'b0001, 16'h0223));
        tbl.push_back(mk(1'b0, 4'b0111, 2'b00, 1, 4'b0000, 4'b0001, 4'b0111, 4'b0110, 16'h0223));
        tbl.push_back(mk(1'b0, 4'b0111, 2'b00, 1, 4'b0000, 4'b0001, 4'b0111, 4'b0000, 16'h0223));
        // both-edge mode: one pulse on ch3 counts twice
        tbl.push_back(mk(1'b0, 4'b1111, 2'b10, 1, 4'b1000, 4'b0001, 4'b1111, 4'b0000, 16'h1223));
        tbl.push_back(mk(1'b0, 4'b0111, 2'b10, 1, 4'b1000, 4'b0001, 4'b1111, 4'b0000, 16'h2223));
        tbl.push_back(mk(1'b0, 4'b0111, 2'b10, 6, 4'b1000, 4'b0001, 4'b1111, 4'b0000, 16'h2223));
        tbl.push_back(mk(1'b0, 4'b0111, 2'b10, 1, 4'b0000, 4'b0001, 4'b1111, 4'b1000, 16'h2223));
        tbl.push_back(mk(1'b0, 4'b0111, 2'b10, 1, 4'b0000, 4'b0001, 4'b1111, 4'b0000, 16'h2223));
        // ch1 window with a rising edge on its closing sample
        tbl.push_back(mk(1'b0, 4'b0101, 2'b00, 1, 4'b0000, 4'b0001, 4'b1111, 4'b0000, 16'h2223));
        tbl.push_back(mk(1'b0, 4'b0111, 2'b00, 1, 4'b0010, 4'b0001, 4'b1111, 4'b0000, 16'h2213));
        tbl.push_back(mk(1'b0, 4'b0101, 2'b00, 1, 4'b0010, 4'b0001, 4'b1111, 4'b0000, 16'h2213));
        tbl.push_back(mk(1'b0, 4'b0111, 2'b00, 1, 4'b0010, 4'b0001, 4'b1111, 4'b0000, 16'h2223));
        tbl.push_back(mk(1'b0, 4'b0111, 2'b00, 4, 4'b0010, 4'b0001, 4'b1111, 4'b0000, 16'h2223));
        tbl.push_back(mk(1'b0, 4'b0101, 2'b00, 1, 4'b0010, 4'b0001, 4'b1111, 4'b0000, 16'h2223));
`ifdef RETRIGGER_EN
        tbl.push_back(mk(1'b0, 4'b0111, 2'b00, 1, 4'b0010, 4'b0001, 4'b1111, 4'b0010, 16'h2213));
        tbl.push_back(mk(1'b0, 4'b0111, 2'b00, 1, 4'b0010, 4'b0001, 4'b1111, 4'b0000, 16'h2213));
        tbl.push_back(mk(1'b0, 4'b0110, 2'b00, 1, 4'b0010, 4'b0001, 4'b1111, 4'b0000, 16'h2213));
        tbl.push_back(mk(1'b0, 4'b0111, 2'b00, 1, 4'b0011, 4'b0000, 4'b1111, 4'b0000, 16'h2211));
`else
        tbl.push_back(mk(1'b0, 4'b0111, 2'b00, 1, 4'b0000, 4'b0001, 4'b1111, 4'b0010, 16'h2223));
        tbl.push_back(mk(1'b0, 4'b0111, 2'b00, 1, 4'b0000, 4'b0001, 4'b1111, 4'b0000, 16'h2223));
        tbl.push_back(mk(1'b0, 4'b0110, 2'b00, 1, 4'b0000, 4'b0001, 4'b1111, 4'b0000, 16'h2223));
        tbl.push_back(mk(1'b0, 4'b0111, 2'b00, 1, 4'b0001, 4'b0000, 4'b1111, 4'b0000, 16'h2221));
`endif
        // clear mid-window: prev keeps tracking, so the held-high inputs give no edge after it
        tbl.push_back(mk(1'b1, 4'b0111, 2'b00, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'h0000));
        tbl.push_back(mk(1'b0, 4'b0111, 2'b00, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'h0000));
        tbl.push_back(mk(1'b0, 4'b0110, 2'b00, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'h0000));
        tbl.push_back(mk(1'b0, 4'b0111, 2'b00, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 16'h0001));

        foreach (tbl[k]) apply(tbl[k]);

        // asynchronous reset between clock edges, mid-window on ch0
        #2;
        reset = 1'b1;
        #1;
        chk_zero("async_reset");
        reset = 1'b0;
        // inputs held high through reset look like rising edges to the cleared prev
        apply(mk(1'b0, 4'b0111, 2'b00, 1, 4'b0111, 4'b0000, 4'b0111, 4'b0000, 16'h0111));

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
